// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: FSM state encoding, frame shape and baud defaults.
package uart_tx_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // 8N1 frame shape
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // 9600 baud at 48 MHz; the formal/simulation build uses a short bit period
    localparam int CLOCKS_PER_BIT_DEFAULT = 5000;
    localparam int CLOCKS_PER_BIT_FORMAL  = 8;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer for the transmitter: counts 0..CLOCKS_PER_BIT-1 while a
// frame is in progress and flags the last clock of every bit. Unlike the Rx
// sampling strobe it starts at zero, so bit_end marks the end of a full bit.
module tx_bit_timer
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic bit_end
);

    localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLOCKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign bit_end = (count == LAST_COUNT);

    // Counter: held at 0 when idle or restarted, wraps to 0 at the end of each bit
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (reset) begin
            count <= '0;
        end else if (restart || !enable || bit_end) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a byte on a valid/ready handshake and sends it as
// one 8N1 frame (start, 8 data bits LSB first, stop), each bit CLOCKS_PER_BIT
// clocks long. All outputs are registered.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_t          state, state_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
    logic                 tx_nxt;
    logic                 handshake;
    logic                 bit_end;

    // tx_ready is high only in IDLE, so a handshake can never collide with a STOP bit_end
    assign handshake = tx_valid & tx_ready;

    tx_bit_timer #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (state != ST_IDLE),
        .restart(handshake),
        .bit_end(bit_end)
    );

    // Next-state, shift register and line value for the coming cycle
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_nxt   = state;
        shift_nxt   = shift;
        bit_idx_nxt = bit_idx;
        tx_nxt      = 1'b1;

        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    state_nxt   = ST_START;
                    shift_nxt   = tx_data;
                    bit_idx_nxt = '0;
                end
            end
            ST_START: begin
                if (bit_end) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_IDX) begin
                        state_nxt = ST_STOP;
                    end else begin
                        shift_nxt   = shift >> 1;
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Registered line value follows the state being entered
        case (state_nxt)
            ST_START: tx_nxt = 1'b0;
            ST_DATA:  tx_nxt = shift_nxt[0];
            default:  tx_nxt = 1'b1;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_nxt;
            shift    <= shift_nxt;
            bit_idx  <= bit_idx_nxt;
            tx       <= tx_nxt;
            tx_ready <= (state_nxt == ST_IDLE);
            tx_busy  <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer with an 8-clock bit period.
// The reference is a frame model: line value at cycle k after acceptance is
// the (k / CPB)-th bit of {stop, data[7:0], start}; a mid-bit sampling
// receiver decodes captured frames for the loopback scenario.
module tb_uart_tx_serializer;

    localparam int CPB   = 8;
    localparam int FRAME = 10 * CPB;
    localparam int CAP_N = 512;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic cap_tx   [0:CAP_N-1];
    logic cap_rdy  [0:CAP_N-1];
    logic cap_busy [0:CAP_N-1];

    uart_tx_serializer #(
        .CLOCKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    // Expected line level k cycles after the accepting edge
    function automatic logic exp_line(input logic [7:0] d, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    // Number of cycles in a captured frame that disagree with the model
    function automatic int frame_errs(input logic [7:0] d, input int base);
        int e;
        e = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (cap_tx[base+k] !== exp_line(d, k) ||
                cap_rdy[base+k] !== 1'b0 || cap_busy[base+k] !== 1'b1)
                e++;
        end
        return e;
    endfunction

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_tx[i]   = tx;
            cap_rdy[i]  = tx_ready;
            cap_busy[i] = tx_busy;
        end
    endtask

    // Present one byte once tx_ready is seen; returns just after the accepting edge
    task automatic do_handshake(input logic [7:0] d);
        int waited;
        waited = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            tests_run++;
            tests_failed++;
            $display("FAIL handshake_timeout: tx_ready=%b after %0d cycles, required 1", tx_ready, waited);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #1;
        tests_run++;
        if ({tx, tx_ready, tx_busy} !== 3'b110) begin
            tests_failed++;
            $display("FAIL reset_values: tx/ready/busy=%b required 110", {tx, tx_ready, tx_busy});
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({tx, tx_ready, tx_busy} !== 3'b110) begin
            tests_failed++;
            $display("FAIL post_reset_idle: tx/ready/busy=%b required 110", {tx, tx_ready, tx_busy});
        end
    endtask

    task automatic test_single_a5();
        logic [9:0] seen;
        logic [9:0] want;
        int e;
        want = 10'b11_0100_1010;  // frame bits 0..9 = 0,1,0,1,0,0,1,0,1,1
        do_handshake(8'hA5);
        capture(FRAME + 4);
        e = frame_errs(8'hA5, 0);
        tests_run++;
        if (e != 0) begin
            tests_failed++;
            $display("FAIL a5_frame_cycles: %0d mismatching cycles, required 0", e);
        end
        for (int i = 0; i < 10; i++) seen[i] = cap_tx[i*CPB + CPB/2];
        tests_run++;
        if (seen !== want) begin
            tests_failed++;
            $display("FAIL a5_bit_sequence: got %b required %b", seen, want);
        end
        tests_run++;
        if (cap_rdy[FRAME] !== 1'b1 || cap_busy[FRAME] !== 1'b0 || cap_tx[FRAME] !== 1'b1) begin
            tests_failed++;
            $display("FAIL a5_ready_at_80: ready=%b busy=%b tx=%b required 1 0 1",
                     cap_rdy[FRAME], cap_busy[FRAME], cap_tx[FRAME]);
        end
    endtask

    task automatic test_back_to_back();
        int e0, e1, start2, hi, tail_bad, waited;
        waited = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2*FRAME + 10; i++) begin
            @(negedge clk);
            cap_tx[i]   = tx;
            cap_rdy[i]  = tx_ready;
            cap_busy[i] = tx_busy;
            if (i == 0) tx_data = 8'hFF;
            if (i == FRAME + 1) tx_valid = 1'b0;
        end
        e0 = frame_errs(8'h00, 0);
        e1 = frame_errs(8'hFF, FRAME + 1);
        tests_run++;
        if (e0 != 0) begin
            tests_failed++;
            $display("FAIL b2b_frame0: %0d mismatching cycles, required 0", e0);
        end
        tests_run++;
        if (cap_rdy[FRAME] !== 1'b1 || cap_tx[FRAME] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_gap_cycle: ready=%b tx=%b required 1 1", cap_rdy[FRAME], cap_tx[FRAME]);
        end
        tests_run++;
        if (e1 != 0) begin
            tests_failed++;
            $display("FAIL b2b_frame1: %0d mismatching cycles, required 0", e1);
        end
        start2 = -1;
        for (int i = CPB; i < 2*FRAME + 10; i++) begin
            if (start2 < 0 && cap_tx[i] === 1'b0 && cap_tx[i-1] === 1'b1) start2 = i;
        end
        tests_run++;
        if (start2 != FRAME + 1) begin
            tests_failed++;
            $display("FAIL b2b_start_spacing: second start at %0d, required %0d", start2, FRAME + 1);
        end
        hi = 0;
        if (start2 > 0) begin
            for (int i = start2 - 1; i >= 0 && cap_tx[i] === 1'b1; i--) hi++;
        end
        tests_run++;
        if (hi != CPB + 1) begin
            tests_failed++;
            $display("FAIL b2b_high_gap: %0d high cycles, required %0d", hi, CPB + 1);
        end
        tail_bad = 0;
        for (int i = 2*FRAME + 1; i < 2*FRAME + 10; i++)
            if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) tail_bad++;
        tests_run++;
        if (tail_bad != 0) begin
            tests_failed++;
            $display("FAIL b2b_idle_after: %0d bad idle cycles, required 0", tail_bad);
        end
    endtask

    task automatic test_data_change();
        int e, tail_bad;
        do_handshake(8'h81);
        for (int i = 0; i < FRAME + 10; i++) begin
            @(negedge clk);
            cap_tx[i]   = tx;
            cap_rdy[i]  = tx_ready;
            cap_busy[i] = tx_busy;
            if (i == 0)  tx_data  = 8'h3C;
            if (i == 20) tx_valid = 1'b1;
            if (i == 21) tx_valid = 1'b0;
        end
        e = frame_errs(8'h81, 0);
        tests_run++;
        if (e != 0) begin
            tests_failed++;
            $display("FAIL busy_ignore_frame: %0d mismatching cycles for 0x81, required 0", e);
        end
        tail_bad = 0;
        for (int i = FRAME; i < FRAME + 10; i++)
            if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0 || cap_rdy[i] !== 1'b1) tail_bad++;
        tests_run++;
        if (tail_bad != 0) begin
            tests_failed++;
            $display("FAIL busy_ignore_no_extra: %0d non-idle cycles after frame, required 0", tail_bad);
        end
    endtask

    task automatic test_reset_midframe();
        int e;
        do_handshake(8'h55);
        repeat (35) @(negedge clk);   // inside data bit 3 (frame bit 4)
        tests_run++;
        if (tx_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midframe_busy: busy=%b required 1", tx_busy);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({tx, tx_ready, tx_busy} !== 3'b110) begin
            tests_failed++;
            $display("FAIL midframe_reset: tx/ready/busy=%b required 110", {tx, tx_ready, tx_busy});
        end
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        capture(FRAME + 2);
        e = frame_errs(8'hC3, 0);
        tests_run++;
        if (e != 0) begin
            tests_failed++;
            $display("FAIL post_reset_c3: %0d mismatching cycles, required 0", e);
        end
        tests_run++;
        if (cap_rdy[FRAME] !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_ready: ready=%b required 1", cap_rdy[FRAME]);
        end
    endtask

    task automatic test_random_loopback();
        logic [7:0] d, rx;
        int data_bad, framing_bad, timing_bad;
        data_bad    = 0;
        framing_bad = 0;
        timing_bad  = 0;
        for (int n = 0; n < 256; n++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_handshake(d);
            capture(FRAME + 1);
            for (int b = 0; b < 8; b++) rx[b] = cap_tx[(b+1)*CPB + CPB/2];
            if (rx !== d) begin
                data_bad++;
                if (data_bad <= 3)
                    $display("FAIL loopback_byte: received %h required %h", rx, d);
            end
            if (cap_tx[CPB/2] !== 1'b0 || cap_tx[9*CPB + CPB/2] !== 1'b1) framing_bad++;
            if (frame_errs(d, 0) != 0 || cap_rdy[FRAME] !== 1'b1) timing_bad++;
        end
        tests_run++;
        if (data_bad != 0) begin
            tests_failed++;
            $display("FAIL loopback_data: %0d corrupted bytes of 256, required 0", data_bad);
        end
        tests_run++;
        if (framing_bad != 0) begin
            tests_failed++;
            $display("FAIL loopback_framing: %0d framing errors, required 0", framing_bad);
        end
        tests_run++;
        if (timing_bad != 0) begin
            tests_failed++;
            $display("FAIL loopback_timing: %0d frames off the bit grid, required 0", timing_bad);
        end
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        tx_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL idle_1000: %0d non-idle cycles, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_data_change();
        test_reset_midframe();
        test_random_loopback();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
